// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined floating-point multiplier with a generic
// exponent/mantissa format, round-to-nearest-even, and exception flags.
// Stage 1 decodes and sums exponents, stage 2 multiplies and normalises,
// and stage 3 rounds, resolves specials and packs the result.
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] p,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           out_flags
);
    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    logic stall;

    logic [EXP_W-1:0] expA, expB;
    logic [MAN_W-1:0] fracA, fracB;
    logic zeroA, zeroB, infA, infB, nanA, nanB;

    logic                 s1Valid_d, s1Sign_d, s1Nan_d, s1Inf_d, s1Zero_d;
    logic signed [EW-1:0] s1Exp_d;
    logic [MAN_W:0]       s1ManA_d, s1ManB_d;
    logic [TAG_W-1:0]     s1Tag_d;
    logic                 s1Valid_q, s1Sign_q, s1Nan_q, s1Inf_q, s1Zero_q;
    logic signed [EW-1:0] s1Exp_q;
    logic [MAN_W:0]       s1ManA_q, s1ManB_q;
    logic [TAG_W-1:0]     s1Tag_q;

    logic [PW-1:0]        prod;
    logic signed [EW-1:0] s2Exp_d;
    logic [MAN_W-1:0]     s2Frac_d;
    logic                 s2Guard_d, s2Sticky_d;
    logic                 s2Valid_q, s2Sign_q, s2Nan_q, s2Inf_q, s2Zero_q;
    logic signed [EW-1:0] s2Exp_q;
    logic [MAN_W-1:0]     s2Frac_q;
    logic                 s2Guard_q, s2Sticky_q;
    logic [TAG_W-1:0]     s2Tag_q;

    logic                 roundUp;
    logic [MAN_W:0]       rounded;
    logic signed [EW-1:0] expR;
    logic [FW-1:0]        s3P_d;
    logic [3:0]           s3Flags_d;
    logic                 s3Valid_q;
    logic [FW-1:0]        s3P_q;
    logic [3:0]           s3Flags_q;
    logic [TAG_W-1:0]     s3Tag_q;

    // A full output that the consumer refuses freezes the whole pipe.
    assign stall     = s3Valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = s3Valid_q;
    assign p         = s3P_q;
    assign out_tag   = s3Tag_q;
    assign out_flags = s3Flags_q;

    // Decode: classify both operands, resolve special-case class and sum exponents.
    always_comb begin
        expA      = a[FW-2:MAN_W];
        expB      = b[FW-2:MAN_W];
        fracA     = a[MAN_W-1:0];
        fracB     = b[MAN_W-1:0];
        zeroA     = (expA == '0);
        zeroB     = (expB == '0);
        infA      = (expA == EXP_ONES) && (fracA == '0);
        infB      = (expB == EXP_ONES) && (fracB == '0);
        nanA      = (expA == EXP_ONES) && (fracA != '0);
        nanB      = (expB == EXP_ONES) && (fracB != '0);
        s1Valid_d = in_valid;
        s1Sign_d  = a[FW-1] ^ b[FW-1];
        s1Nan_d   = nanA | nanB | (infA & zeroB) | (zeroA & infB);
        s1Inf_d   = infA | infB;
        s1Zero_d  = zeroA | zeroB;
        s1Exp_d   = $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS;
        s1ManA_d  = {1'b1, fracA};
        s1ManB_d  = {1'b1, fracB};
        s1Tag_d   = in_tag;
    end

    // Stage 1 register: loads decoded operands whenever the pipe is moving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Sign_q  <= 1'b0;
            s1Nan_q   <= 1'b0;
            s1Inf_q   <= 1'b0;
            s1Zero_q  <= 1'b0;
            s1Exp_q   <= '0;
            s1ManA_q  <= '0;
            s1ManB_q  <= '0;
            s1Tag_q   <= '0;
        end else if (!stall) begin
            s1Valid_q <= s1Valid_d;
            s1Sign_q  <= s1Sign_d;
            s1Nan_q   <= s1Nan_d;
            s1Inf_q   <= s1Inf_d;
            s1Zero_q  <= s1Zero_d;
            s1Exp_q   <= s1Exp_d;
            s1ManA_q  <= s1ManA_d;
            s1ManB_q  <= s1ManB_d;
            s1Tag_q   <= s1Tag_d;
        end
    end

    // Multiply significands and normalise: a product in [2,4) bumps the exponent.
    always_comb begin
        prod = PW'(s1ManA_q) * PW'(s1ManB_q);
        if (prod[PW-1]) begin
            s2Exp_d    = s1Exp_q + EW'(1);
            s2Frac_d   = prod[PW-2 -: MAN_W];
            s2Guard_d  = prod[MAN_W];
            s2Sticky_d = |prod[MAN_W-1:0];
        end else begin
            s2Exp_d    = s1Exp_q;
            s2Frac_d   = prod[PW-3 -: MAN_W];
            s2Guard_d  = prod[MAN_W-1];
            s2Sticky_d = |prod[MAN_W-2:0];
        end
    end

    // Stage 2 register: normalised fraction with guard/sticky for rounding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid_q  <= 1'b0;
            s2Sign_q   <= 1'b0;
            s2Nan_q    <= 1'b0;
            s2Inf_q    <= 1'b0;
            s2Zero_q   <= 1'b0;
            s2Exp_q    <= '0;
            s2Frac_q   <= '0;
            s2Guard_q  <= 1'b0;
            s2Sticky_q <= 1'b0;
            s2Tag_q    <= '0;
        end else if (!stall) begin
            s2Valid_q  <= s1Valid_q;
            s2Sign_q   <= s1Sign_q;
            s2Nan_q    <= s1Nan_q;
            s2Inf_q    <= s1Inf_q;
            s2Zero_q   <= s1Zero_q;
            s2Exp_q    <= s2Exp_d;
            s2Frac_q   <= s2Frac_d;
            s2Guard_q  <= s2Guard_d;
            s2Sticky_q <= s2Sticky_d;
            s2Tag_q    <= s1Tag_q;
        end
    end

    // Round to nearest even, then resolve specials and range limits in priority order.
    always_comb begin
        roundUp   = s2Guard_q & (s2Sticky_q | s2Frac_q[0]);
        rounded   = {1'b0, s2Frac_q} + {{MAN_W{1'b0}}, roundUp};
        expR      = s2Exp_q + $signed({{(EW-1){1'b0}}, rounded[MAN_W]});
        s3P_d     = {s2Sign_q, expR[EXP_W-1:0], rounded[MAN_W-1:0]};
        s3Flags_d = {3'b000, s2Guard_q | s2Sticky_q};
        if (s2Nan_q) begin
            s3P_d     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            s3Flags_d = 4'b1000;
        end else if (s2Inf_q) begin
            s3P_d     = {s2Sign_q, EXP_ONES, {MAN_W{1'b0}}};
            s3Flags_d = 4'b0000;
        end else if (s2Zero_q) begin
            s3P_d     = {s2Sign_q, {(FW-1){1'b0}}};
            s3Flags_d = 4'b0000;
        end else if (expR >= EXP_MAX) begin
            s3P_d     = {s2Sign_q, EXP_ONES, {MAN_W{1'b0}}};
            s3Flags_d = 4'b0101;
        end else if (expR[EW-1] || (expR == '0)) begin
            s3P_d     = {s2Sign_q, {(FW-1){1'b0}}};
            s3Flags_d = 4'b0011;
        end
    end

    // Stage 3 register: the packed result presented to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3Valid_q <= 1'b0;
            s3P_q     <= '0;
            s3Flags_q <= '0;
            s3Tag_q   <= '0;
        end else if (!stall) begin
            s3Valid_q <= s2Valid_q;
            s3P_q     <= s3P_d;
            s3Flags_q <= s3Flags_d;
            s3Tag_q   <= s2Tag_q;
        end
    end
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: scoreboard bench for fmul_pipe (bf16 instance plus an fp16 instance).
module tb_fmul_pipe;
    typedef struct {
        logic [15:0] p;
        logic [3:0]  tag;
        logic [3:0]  flags;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] p;
    logic [3:0]  out_tag;
    logic [3:0]  out_flags;

    logic        hInValid = 1'b0;
    logic        hInReady;
    logic [15:0] hA = '0;
    logic [15:0] hB = '0;
    logic [3:0]  hInTag = '0;
    logic        hOutValid;
    logic        hOutReady = 1'b1;
    logic [15:0] hP;
    logic [3:0]  hOutTag;
    logic [3:0]  hOutFlags;

    int  tests = 0;
    int  fails = 0;
    int  issued = 0;
    int  discarded = 0;
    int  outCount = 0;
    bit  randReady = 1'b0;
    bit  readyLevel = 1'b1;
    expT expQ[$];

    fmul_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .out_tag(out_tag), .out_flags(out_flags)
    );

    fmul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dutHalf (
        .clk(clk), .rst_n(rst_n), .in_valid(hInValid), .in_ready(hInReady),
        .a(hA), .b(hB), .in_tag(hInTag), .out_valid(hOutValid), .out_ready(hOutReady),
        .p(hP), .out_tag(hOutTag), .out_flags(hOutFlags)
    );

    initial forever #5 clk = ~clk;

    // Reference product from the arithmetic rules: returns {flags, result} packed in an int.
    function automatic int refMul(input int expW, input int manW, input int x, input int y);
        int fw, emax, bias, ea, eb, fa, fb, e, shift, sign, inexact;
        longint prodVal, q, rem, half;
        bit nanX, nanY, infX, infY, zeroX, zeroY;
        fw    = 1 + expW + manW;
        emax  = (1 << expW) - 1;
        bias  = (1 << (expW - 1)) - 1;
        sign  = ((x >> (fw - 1)) ^ (y >> (fw - 1))) & 1;
        ea    = (x >> manW) & emax;
        eb    = (y >> manW) & emax;
        fa    = x & ((1 << manW) - 1);
        fb    = y & ((1 << manW) - 1);
        nanX  = (ea == emax) && (fa != 0);
        nanY  = (eb == emax) && (fb != 0);
        infX  = (ea == emax) && (fa == 0);
        infY  = (eb == emax) && (fb == 0);
        zeroX = (ea == 0);
        zeroY = (eb == 0);
        if (nanX || nanY || (infX && zeroY) || (zeroX && infY))
            return (8 << fw) | (emax << manW) | (1 << (manW - 1));
        if (infX || infY) return (sign << (fw - 1)) | (emax << manW);
        if (zeroX || zeroY) return sign << (fw - 1);
        prodVal = longint'(fa + (1 << manW)) * longint'(fb + (1 << manW));
        e       = ea + eb - bias;
        shift   = manW;
        if (prodVal >= (longint'(1) << (2 * manW + 1))) begin
            shift++;
            e++;
        end
        q       = prodVal >> shift;
        rem     = prodVal - (q << shift);
        half    = longint'(1) << (shift - 1);
        inexact = (rem != 0) ? 1 : 0;
        if (rem > half || (rem == half && q[0] == 1'b1)) q++;
        if (q == (longint'(1) << (manW + 1))) begin
            q = longint'(1) << manW;
            e++;
        end
        if (e >= emax) return (5 << fw) | (sign << (fw - 1)) | (emax << manW);
        if (e <= 0) return (3 << fw) | (sign << (fw - 1));
        return (inexact << fw) | (sign << (fw - 1)) | (e << manW) | int'(q - (longint'(1) << manW));
    endfunction

    // Biased random bf16 operand: mostly mid-range, some extremes and specials.
    function automatic logic [15:0] randOperand();
        logic [15:0] specials [7];
        int pick;
        specials = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC1, 16'h0080, 16'h7F7F};
        pick = $urandom_range(0, 99);
        if (pick < 10) return specials[$urandom_range(0, 6)];
        if (pick < 20) return {1'($urandom), 8'($urandom_range(1, 6)), 7'($urandom)};
        if (pick < 30) return {1'($urandom), 8'($urandom_range(248, 254)), 7'($urandom)};
        return {1'($urandom), 8'($urandom_range(64, 190)), 7'($urandom)};
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one operand pair, hold until accepted, then record the expected result.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic [3:0] tag);
        int r;
        int waitCnt;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        in_tag   = tag;
        waitCnt  = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waitCnt++;
            if (waitCnt > 200) begin
                checkOutput("accept_timeout", 0, 1);
                break;
            end
        end
        r = refMul(8, 7, int'(x), int'(y));
        expQ.push_back('{p: r[15:0], tag: tag, flags: r[19:16]});
        issued++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after applyStimulus returns: result appears on the third edge.
    task automatic checkLatency(input string name);
        checkOutput({name, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        checkOutput({name, "_lat2"}, out_valid, 0);
        @(posedge clk); #1;
        checkOutput({name, "_lat3"}, out_valid, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
        @(posedge clk); #1;
    endtask

    // Single fp16 operation on the second instance against an expected word.
    task automatic halfCase(input string name, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] expP, input logic [3:0] expF);
        int n;
        hA       = x;
        hB       = y;
        hInValid = 1'b1;
        @(posedge clk); #1;
        hInValid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hOutValid && n < 10);
        checkOutput({name, "_valid"}, hOutValid, 1);
        checkOutput({name, "_p"}, hP, expP);
        checkOutput({name, "_flags"}, hOutFlags, expF);
        @(posedge clk); #1;
    endtask

    // Consumer readiness: fixed level or random toggling, changed just after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
    end

    // Monitor: checks the handshake relation, stall stability, and pops the scoreboard.
    initial begin
        bit          prevStall;
        logic [23:0] prevWord;
        expT         e;
        prevStall = 1'b0;
        prevWord  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevStall = 1'b0;
                continue;
            end
            checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
            if (prevStall) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_hold", {out_tag, out_flags, p}, prevWord);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", p, 0);
                    if (p == 16'h0) checkOutput("unexpected_output_valid", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("p", p, e.p);
                    checkOutput("tag", out_tag, e.tag);
                    checkOutput("flags", out_flags, e.flags);
                end
                outCount++;
            end
            prevStall = out_valid && !out_ready;
            prevWord  = {out_tag, out_flags, p};
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: reset, directed cases, backpressure stream, mid-stream reset, fp16.
    initial begin
        logic [15:0] dirA [9];
        logic [15:0] dirB [9];
        dirA = '{16'h3FC0, 16'h3FC0, 16'h3F81, 16'h3F81, 16'h7F7F, 16'h7F80, 16'hFF80, 16'h0080, 16'h8000};
        dirB = '{16'h4000, 16'h3FC0, 16'h3FC0, 16'h3F81, 16'h4000, 16'h0000, 16'h4000, 16'h0080, 16'h3F80};

        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_p", p, 0);
        checkOutput("reset_tag", out_tag, 0);
        checkOutput("reset_flags", out_flags, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_in_ready", in_ready, 1);

        applyStimulus(dirA[0], dirB[0], 4'h1);
        checkLatency("first");
        for (int i = 1; i < 9; i++) applyStimulus(dirA[i], dirB[i], 4'(i + 1));
        drain();

        randReady = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(dirA[i], dirB[i], 4'(i + 8));
        for (int i = 0; i < 60; i++) applyStimulus(randOperand(), randOperand(), 4'($urandom));
        randReady = 1'b0;
        drain();

        readyLevel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(randOperand(), randOperand(), 4'(i + 3));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_async_drop", out_valid, 0);
        discarded = discarded + expQ.size();
        expQ.delete();
        readyLevel = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        applyStimulus(16'h3FC0, 16'h4000, 4'hA);
        checkLatency("fresh");
        drain();
        checkOutput("output_count", outCount, issued - discarded);

        halfCase("fp16_one_two", 16'h3C00, 16'h4000, 16'h4000, 4'b0000);
        halfCase("fp16_ovf", 16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] x, y;
            int r;
            x = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
            y = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
            r = refMul(5, 10, int'(x), int'(y));
            halfCase("fp16_rand", x, y, r[15:0], r[19:16]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
